fft_mux_pipe: RTL and testbench

FFT_MUX_PIPE -- requirements
Module: fft_mux_pipe

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_mux_stage.sv | 80 ++++++++
 rtl/fft_mux_pipe.sv | 165 ++++++++++++++++
 tb/tb_fft_mux_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the fft_mux_pipe block.
// Contents:
//   fft_state_e - auto-sequence FSM states (IDLE / RUN / DRAIN)
//   sel_width   - index width derived from digit width and stage count
//   bit_rev     - reverse the low 'width' bits of a value
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fft_state_e;

    function automatic int sel_width(input int radix_log2, input int stages);
        return radix_log2 * stages;
    endfunction

    // Bits at or above 'width' come back as zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] val, input int width);
        logic [31:0] res;
        res = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                res[5'(i)] = val[5'(width - 1 - i)];
            end else begin
                res[5'(i)] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_mux_stage.sv
// One registered 2**RADIX_LOG2-to-1 digit stage of the index pipeline.
// Output lane j takes input lane (digit * LANES_OUT + j), where the digit is
// idx_i[DIGIT_LSB +: RADIX_LOG2]. The index, valid and last flags travel
// alongside the data so later stages see the same issue.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   valid_i, last_i    - issue strobe / final-sample flag entering the stage
//   idx_i              - full sample index of this issue
//   data_i[LANES_IN]   - candidate lanes
//   valid_o, last_o    - registered strobes
//   idx_o              - registered index (holds while idle)
//   data_o[LANES_OUT]  - registered selected lanes (hold while idle)
module fft_mux_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int RADIX_LOG2 = 4,
    parameter int SEL_W      = 8,
    parameter int DIGIT_LSB  = 4,
    parameter int LANES_OUT  = 16,
    localparam int RADIX     = 1 << RADIX_LOG2,
    localparam int LANES_IN  = LANES_OUT * RADIX
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  last_i,
    input  logic [SEL_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] data_i [LANES_IN],
    output logic                  valid_o,
    output logic                  last_o,
    output logic [SEL_W-1:0]      idx_o,
    output logic [DATA_WIDTH-1:0] data_o [LANES_OUT]
);

    logic [RADIX_LOG2-1:0] digit_s;
    logic                  valid_q;
    logic                  last_q;
    logic [SEL_W-1:0]      idx_q;

    assign digit_s = idx_i[DIGIT_LSB +: RADIX_LOG2];

    // Sideband register: valid/last follow every cycle, index only on a real issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_i;
            last_q  <= valid_i & last_i;
            if (valid_i) begin
                idx_q <= idx_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign idx_o   = idx_q;

    for (genvar j = 0; j < LANES_OUT; j++) begin : g_lane
        logic [DATA_WIDTH-1:0] cand_s [RADIX];
        logic [DATA_WIDTH-1:0] lane_q;

        for (genvar d = 0; d < RADIX; d++) begin : g_cand
            assign cand_s[d] = data_i[d * LANES_OUT + j];
        end

        // Lane register: capture the digit-selected candidate on issue, hold otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_q <= '0;
            end else if (valid_i) begin
                lane_q <= cand_s[digit_s];
            end
        end

        assign data_o[j] = lane_q;
    end

endmodule

// File: rtl/fft_mux_pipe.sv
// Pipelined N-to-1 sample selector for a parallel FFT vector.
// The index is resolved RADIX_LOG2 bits per stage, most significant digit
// first, giving a latency of STAGES cycles and one index per cycle.
// Indices come from sel_i (external mode) or from an internal counter that
// walks 0..N-1, optionally bit-reversed (auto mode).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   mode_i      - 0 external select, 1 auto sequence (sampled in IDLE only)
//   bitrev_i    - auto sequence issues bit-reversed indices (captured at start)
//   start_i     - auto-mode start pulse
//   valid_i     - external-mode request strobe
//   sel_i       - external-mode index
//   data_i[N]   - parallel sample vector, held stable while busy_o
//   data_o      - selected sample
//   idx_o       - index of the sample on data_o
//   valid_o     - data_o/idx_o valid
//   last_o      - final sample of an auto sequence
//   busy_o      - auto sequence in progress
module fft_mux_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RADIX_LOG2 = 4,
    parameter int STAGES     = 2,
    localparam int SEL_W     = sel_width(RADIX_LOG2, STAGES),
    localparam int N         = 1 << SEL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode_i,
    input  logic                  bitrev_i,
    input  logic                  start_i,
    input  logic                  valid_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [DATA_WIDTH-1:0] data_i [N],
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [SEL_W-1:0]      idx_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic                  busy_o
);

    fft_state_e        state_q, state_d;
    logic [SEL_W-1:0]  cnt_q, cnt_d;
    logic              bitrev_q, bitrev_d;
    logic              busy_q;
    logic [SEL_W-1:0]  rev_s;
    logic              iss_valid_s;
    logic              iss_last_s;
    logic [SEL_W-1:0]  iss_idx_s;

    assign rev_s = SEL_W'(bit_rev(32'(cnt_q), SEL_W));

    // Control registers for the auto sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitrev_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitrev_q <= bitrev_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Next-state and issue logic. DRAIN ends on the cycle the last sample is presented.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitrev_d    = bitrev_q;
        iss_valid_s = 1'b0;
        iss_last_s  = 1'b0;
        iss_idx_s   = '0;
        case (state_q)
            ST_IDLE: begin
                if (mode_i) begin
                    if (start_i) begin
                        state_d  = ST_RUN;
                        cnt_d    = '0;
                        bitrev_d = bitrev_i;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    iss_valid_s = valid_i;
                    iss_idx_s   = sel_i;
                end
            end
            ST_RUN: begin
                iss_valid_s = 1'b1;
                iss_idx_s   = bitrev_q ? rev_s : cnt_q;
                if (cnt_q == {SEL_W{1'b1}}) begin
                    iss_last_s = 1'b1;
                    state_d    = ST_DRAIN;
                    cnt_d      = '0;
                end else begin
                    cnt_d      = cnt_q + SEL_W'(1);
                end
            end
            ST_DRAIN: begin
                if (last_o) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = busy_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LANES_OUT = 1 << (RADIX_LOG2 * (STAGES - 1 - k));
        localparam int LANES_IN  = LANES_OUT << RADIX_LOG2;

        logic [DATA_WIDTH-1:0] din_s  [LANES_IN];
        logic [DATA_WIDTH-1:0] dout_s [LANES_OUT];
        logic                  vin_s, lin_s, vout_s, lout_s;
        logic [SEL_W-1:0]      iin_s, iout_s;

        if (k == 0) begin : g_head
            assign din_s = data_i;
            assign vin_s = iss_valid_s;
            assign lin_s = iss_last_s;
            assign iin_s = iss_idx_s;
        end else begin : g_tail
            assign din_s = g_stage[k-1].dout_s;
            assign vin_s = g_stage[k-1].vout_s;
            assign lin_s = g_stage[k-1].lout_s;
            assign iin_s = g_stage[k-1].iout_s;
        end

        fft_mux_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .RADIX_LOG2 (RADIX_LOG2),
            .SEL_W      (SEL_W),
            .DIGIT_LSB  (SEL_W - (k + 1) * RADIX_LOG2),
            .LANES_OUT  (LANES_OUT)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (vin_s),
            .last_i  (lin_s),
            .idx_i   (iin_s),
            .data_i  (din_s),
            .valid_o (vout_s),
            .last_o  (lout_s),
            .idx_o   (iout_s),
            .data_o  (dout_s)
        );
    end

    assign data_o  = g_stage[STAGES-1].dout_s[0];
    assign idx_o   = g_stage[STAGES-1].iout_s;
    assign valid_o = g_stage[STAGES-1].vout_s;
    assign last_o  = g_stage[STAGES-1].lout_s;

endmodule

// File: tb/tb_fft_mux_pipe.sv
module tb_fft_mux_pipe;

    typedef struct {
        logic [7:0] idx;
        logic [7:0] data;
        logic       last;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    // main DUT (N = 256, two stages)
    logic       mode_i, bitrev_i, start_i, valid_i;
    logic [7:0] sel_i;
    logic [7:0] data_i [256];
    logic [7:0] data_o, idx_o;
    logic       valid_o, last_o, busy_o;
    // sweep DUTs (N = 8), shared stimulus
    logic       mode8, bitrev8, start8, valid8;
    logic [2:0] sel8;
    logic [7:0] data8 [8];
    logic [7:0] data_a, data_b;
    logic [2:0] idx_a, idx_b;
    logic       valid_a, valid_b, last_a, last_b, busy_a, busy_b;

    exp_t sb[$], sb_a[$], sb_b[$];
    exp_t em, ea, eb;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_mux_pipe #(.DATA_WIDTH(8), .RADIX_LOG2(4), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .bitrev_i(bitrev_i),
        .start_i(start_i), .valid_i(valid_i), .sel_i(sel_i), .data_i(data_i),
        .data_o(data_o), .idx_o(idx_o), .valid_o(valid_o), .last_o(last_o),
        .busy_o(busy_o));

    fft_mux_pipe #(.DATA_WIDTH(8), .RADIX_LOG2(3), .STAGES(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .mode_i(mode8), .bitrev_i(bitrev8),
        .start_i(start8), .valid_i(valid8), .sel_i(sel8), .data_i(data8),
        .data_o(data_a), .idx_o(idx_a), .valid_o(valid_a), .last_o(last_a),
        .busy_o(busy_a));

    fft_mux_pipe #(.DATA_WIDTH(8), .RADIX_LOG2(1), .STAGES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mode_i(mode8), .bitrev_i(bitrev8),
        .start_i(start8), .valid_i(valid8), .sel_i(sel8), .data_i(data8),
        .data_o(data_b), .idx_o(idx_b), .valid_o(valid_b), .last_o(last_b),
        .busy_o(busy_b));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int brev(input int v, input int w);
        int r;
        r = 0;
        for (int i = 0; i < w; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Scoreboard monitors: every valid output must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n && valid_o) begin
            if (sb.size() == 0) begin
                check_val("main_spurious_valid", 32'(valid_o), 32'd0);
            end else begin
                em = sb.pop_front();
                check_val("main_idx",  32'(idx_o),  32'(em.idx));
                check_val("main_data", 32'(data_o), 32'(em.data));
                check_val("main_last", 32'(last_o), 32'(em.last));
                check_val("main_cycle", 32'(cyc), 32'(em.due));
                if (em.last) check_val("main_busy_at_last", 32'(busy_o), 32'd1);
                out_cnt++;
            end
        end else if (rst_n && last_o) begin
            check_val("main_last_without_valid", 32'(last_o), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid_a) begin
            if (sb_a.size() == 0) begin
                check_val("n8a_spurious_valid", 32'(valid_a), 32'd0);
            end else begin
                ea = sb_a.pop_front();
                check_val("n8a_idx",   32'(idx_a),  32'(ea.idx));
                check_val("n8a_data",  32'(data_a), 32'(ea.data));
                check_val("n8a_last",  32'(last_a), 32'(ea.last));
                check_val("n8a_cycle", 32'(cyc),    32'(ea.due));
            end
        end
        if (rst_n && valid_b) begin
            if (sb_b.size() == 0) begin
                check_val("n8b_spurious_valid", 32'(valid_b), 32'd0);
            end else begin
                eb = sb_b.pop_front();
                check_val("n8b_idx",   32'(idx_b),  32'(eb.idx));
                check_val("n8b_data",  32'(data_b), 32'(eb.data));
                check_val("n8b_last",  32'(last_b), 32'(eb.last));
                check_val("n8b_cycle", 32'(cyc),    32'(eb.due));
            end
        end
    end

    task automatic push_main(input int idx, input int last, input int due);
        exp_t e;
        e.idx = 8'(idx); e.data = data_i[idx]; e.last = (last != 0); e.due = due;
        sb.push_back(e);
    endtask

    task automatic ext_issue(input logic [7:0] sel);
        mode_i = 1'b0; valid_i = 1'b1; sel_i = sel;
        push_main(int'(sel), 0, cyc + 2);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    // Returns one cycle after start, with the counter at 0.
    task automatic auto_start(input logic rev);
        int k;
        k = cyc;
        mode_i = 1'b1; bitrev_i = rev; start_i = 1'b1;
        for (int j = 0; j < 256; j++)
            push_main(rev ? brev(j, 8) : j, (j == 255) ? 1 : 0, k + 3 + j);
        @(negedge clk);
        start_i = 1'b0; bitrev_i = ~rev;
    endtask

    task automatic push8(input int idx, input int last, input int due_a, input int due_b);
        exp_t e;
        e.idx = 8'(idx); e.data = data8[idx]; e.last = (last != 0);
        e.due = due_a; sb_a.push_back(e);
        e.due = due_b; sb_b.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() + sb_a.size() + sb_b.size()) != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(sb.size() + sb_a.size() + sb_b.size()), 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        mode_i = 1'b0; bitrev_i = 1'b0; start_i = 1'b0; valid_i = 1'b0; sel_i = 8'd0;
        mode8 = 1'b0; bitrev8 = 1'b0; start8 = 1'b0; valid8 = 1'b0; sel8 = 3'd0;
        for (int i = 0; i < 256; i++) data_i[i] = 8'(i);
        for (int i = 0; i < 8; i++) data8[i] = 8'(8'h30 + 7 * i);
        #12;
        check_val("rst_valid", 32'(valid_o), 32'd0);
        check_val("rst_busy",  32'(busy_o),  32'd0);
        check_val("rst_last",  32'(last_o),  32'd0);
        check_val("rst_data",  32'(data_o),  32'd0);
        check_val("rst_idx",   32'(idx_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_valid", 32'(valid_o), 32'd0);

        // external mode, back-to-back
        ext_issue(8'h00); ext_issue(8'h7F); ext_issue(8'hFF);
        wait_drain("ext_drain");
        repeat (2) @(negedge clk);
        check_val("hold_data",  32'(data_o),  32'hFF);
        check_val("hold_idx",   32'(idx_o),   32'hFF);
        check_val("hold_valid", 32'(valid_o), 32'd0);

        // auto sequential
        out_cnt = 0;
        auto_start(1'b0);
        check_val("busy_in_run", 32'(busy_o), 32'd1);
        wait_drain("seq_drain");
        @(negedge clk);
        check_val("seq_busy_fall", 32'(busy_o), 32'd0);
        check_val("seq_count", 32'(out_cnt), 32'd256);

        // auto bit-reversed with a different data pattern
        for (int i = 0; i < 256; i++) data_i[i] = 8'(i) ^ 8'h5A;
        out_cnt = 0;
        auto_start(1'b1);
        wait_drain("rev_drain");
        @(negedge clk);
        check_val("rev_busy_fall", 32'(busy_o), 32'd0);
        check_val("rev_count", 32'(out_cnt), 32'd256);

        // ignored start/valid/mode changes in the middle of a run
        out_cnt = 0;
        auto_start(1'b0);
        repeat (100) @(negedge clk);
        start_i = 1'b1; valid_i = 1'b1; sel_i = 8'h05; mode_i = 1'b0; bitrev_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; valid_i = 1'b0;
        wait_drain("ign_drain");
        @(negedge clk);
        check_val("ign_busy_fall", 32'(busy_o), 32'd0);
        check_val("ign_count", 32'(out_cnt), 32'd256);

        // reset in the middle of a run
        auto_start(1'b0);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(valid_o), 32'd0);
        check_val("mid_rst_busy",  32'(busy_o),  32'd0);
        check_val("mid_rst_last",  32'(last_o),  32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_cnt = 0;
        repeat (20) @(negedge clk);
        check_val("post_mid_rst_outputs", 32'(out_cnt), 32'd0);
        check_val("post_mid_rst_busy", 32'(busy_o), 32'd0);

        // N = 8 sweep: latency 1 vs 3, same order
        for (int i = 0; i < 8; i++) begin
            mode8 = 1'b0; valid8 = 1'b1; sel8 = 3'(7 - i);
            push8(7 - i, 0, cyc + 1, cyc + 3);
            @(negedge clk);
        end
        valid8 = 1'b0;
        k = cyc;
        mode8 = 1'b1; bitrev8 = 1'b1; start8 = 1'b1;
        for (int j = 0; j < 8; j++)
            push8(brev(j, 3), (j == 7) ? 1 : 0, k + 2 + j, k + 4 + j);
        @(negedge clk);
        start8 = 1'b0; bitrev8 = 1'b0;
        wait_drain("sweep_drain");
        repeat (2) @(negedge clk);
        check_val("sweep_busy_a", 32'(busy_a), 32'd0);
        check_val("sweep_busy_b", 32'(busy_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
